// File: rtl/add_share_arbiter_pkg.sv
// add_share_pkg: shared types and the round-robin pick helper for add_share_arbiter
// Provides state_t, pick_t, idx_w() for index widths, and rr_pick() for up to MAX_REQ requesters.
package add_share_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int MAX_REQ = 8;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;
  // A 1-requester build still needs a 1-bit index, so clamp to at least 1.
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Scans from ptr upward modulo n; walking k downward lets the nearest hit win last.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr, input int n);
    pick_t p;
    int j;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = j >= n ? j - n : j;
      if (k < n && valid[j[2:0]]) begin
        p.found = 1'b1;
        p.idx   = j[2:0];
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/add_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting at ptr
// Ports: req requests, ptr search start, enable gate; grant one-hot, grant_idx index, found any granted.
module rr_arbiter
  import add_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             found
);
  pick_t pick;
  always_comb begin
    pick      = rr_pick(MAX_REQ'(req), 3'(ptr), NREQ);
    found     = enable & pick.found;
    grant_idx = pick.idx[IDX_W-1:0];
    grant     = found ? NREQ'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/std_add.sv
// std_add: plain modulo-2^WIDTH adder, carry discarded
// Ports: left, right operands; out sum.
module std_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out
);
  assign out = left + right;
endmodule

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: one adder and one result register shared round-robin by NREQ requesters
// Ports: clk; reset (async, active-low); req_valid/req_ready/req_left/req_right request side;
// resp_valid/resp_ready/resp_data response side (one-hot to owner); busy result held; ops_done response count.
module add_share_arbiter
  import add_share_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_left,
  input  logic [NREQ*WIDTH-1:0] req_right,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);
  localparam int IDX_W = idx_w(NREQ);
  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  grant_idx;
  logic [NREQ-1:0]   grant;
  logic              found;
  logic              resp_hs;
  logic [WIDTH-1:0]  sum;
  assign resp_hs = resp_valid[owner] & resp_ready[owner];
  // Arbitrate when empty or when the held result leaves this cycle; gated by reset so nothing is granted during reset.
  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (reset && (state == IDLE || resp_hs)),
    .grant     (grant),
    .grant_idx (grant_idx),
    .found     (found)
  );
  assign req_ready = grant;
  std_add #(.WIDTH(WIDTH)) u_add (
    .left  (req_left[grant_idx*WIDTH +: WIDTH]),
    .right (req_right[grant_idx*WIDTH +: WIDTH]),
    .out   (sum)
  );
  assign busy = state == HOLD;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      ops_done   <= '0;
    end else begin
      ops_done <= ops_done + CNT_W'(resp_hs);
      if (found) begin
        state      <= HOLD;
        owner      <= grant_idx;
        resp_valid <= grant;
        resp_data  <= sum;
        rr_ptr     <= grant_idx == IDX_W'(NREQ - 1) ? '0 : grant_idx + 1'b1;
      end else if (resp_hs) begin
        state      <= IDLE;
        resp_valid <= '0;
      end
    end
  end
endmodule
